// File: rtl/arm_imem_loader.sv
// rtl/arm_imem_loader.sv - encodes decoded ARM instruction fields into words and writes them sequentially into imem
// Optional: ENC_ABS_BRANCH_EN converts an absolute branch target into a PC+8-relative imm24.
module arm_imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic              in_imm,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   count_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    logic              dp_legal;
    logic              legal;
    logic              accept;
    logic              is_cmp;
    logic [23:0]       imm24;
    logic [31:0]       word;

    always_comb begin
        dp_legal = 1'b0;
        case (in_cmd)
            4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0001: dp_legal = 1'b1;
            default: dp_legal = 1'b0;
        endcase
    end

    assign legal  = (in_op == 2'b00) ? dp_legal : (in_op != 2'b11);
    assign accept = (state == IDLE) && in_valid && !clear;
    assign is_cmp = (in_cmd == 4'b1010);

`ifdef ENC_ABS_BRANCH_EN
    // Branch offset is relative to PC+8, i.e. two words past this slot.
    assign imm24 = in_target - (24'(count_q[ADDR_W-1:0]) + 24'd2);
`else
    assign imm24 = in_target;
`endif

    always_comb begin
        word = 32'h0;
        case (in_op)
            2'b00: word = {in_cond, 2'b00, in_imm, in_cmd, (in_s | is_cmp), in_rn,
                           (is_cmp ? 4'b0000 : in_rd), in_src2};
            // Pre-indexed, add offset, word access, no writeback; I bit is inverted for memory ops.
            2'b01: word = {in_cond, 2'b01, ~in_imm, 1'b1, 1'b1, 1'b0, 1'b0, in_cmd[0],
                           in_rn, in_rd, in_src2};
            2'b10: word = {in_cond, 4'b1010, imm24};
            default: word = 32'h0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept && legal) state_nx = WRITE;
            WRITE: begin
                if (clear)
                    state_nx = IDLE;
                else if (count_q + 1'b1 == (ADDR_W + 1)'(DEPTH))
                    state_nx = FULL;
                else
                    state_nx = IDLE;
            end
            FULL:  if (clear) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            we_q  <= accept && legal;
            if (accept && legal) begin
                addr_q  <= count_q[ADDR_W-1:0];
                wdata_q <= word;
            end
            if (clear)
                count_q <= '0;
            else if (state == WRITE)
                count_q <= count_q + 1'b1;
            if (clear)
                err_q <= 1'b0;
            else if (accept && !legal)
                err_q <= 1'b1;
        end
    end

    assign in_ready   = (state == IDLE);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (state == FULL);
    assign err        = err_q;

endmodule

// File: tb/tb_arm_imem_loader.sv
// tb/tb_arm_imem_loader.sv - directed self-checking bench for arm_imem_loader
module tb_arm_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_cond;
    logic [1:0]  in_op;
    logic [3:0]  in_cmd;
    logic        in_s;
    logic        in_imm;
    logic [3:0]  in_rn;
    logic [3:0]  in_rd;
    logic [11:0] in_src2;
    logic [23:0] in_target;

    logic        clear_a, valid_a, ready_a, we_a, full_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wdata_a;
    logic [6:0]  count_a;

    logic        clear_b, valid_b, ready_b, we_b, full_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    arm_imem_loader #(.ADDR_W(6)) dut_a (
        .clk(clk), .reset(reset), .clear(clear_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_cond(in_cond), .in_op(in_op), .in_cmd(in_cmd), .in_s(in_s), .in_imm(in_imm),
        .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_target(in_target),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .count(count_a),
        .full(full_a), .err(err_a)
    );

    arm_imem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .clear(clear_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_cond(in_cond), .in_op(in_op), .in_cmd(in_cmd), .in_s(in_s), .in_imm(in_imm),
        .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_target(in_target),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .count(count_b),
        .full(full_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [3:0] cond, input logic [1:0] op, input logic [3:0] cmd,
                              input logic s, input logic imm, input logic [3:0] rn,
                              input logic [3:0] rd, input logic [11:0] src2,
                              input logic [23:0] target);
        in_cond = cond; in_op = op; in_cmd = cmd; in_s = s; in_imm = imm;
        in_rn = rn; in_rd = rd; in_src2 = src2; in_target = target;
    endtask

    task automatic write_a(input string tag, input int exp_addr, input logic [31:0] exp_word,
                           input int exp_count);
        @(negedge clk);
        check({tag, ".ready"}, 32'(ready_a), 32'd1);
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check({tag, ".we"}, 32'(we_a), 32'd1);
        check({tag, ".addr"}, 32'(addr_a), 32'(exp_addr));
        check({tag, ".wdata"}, wdata_a, exp_word);
        check({tag, ".ready_in_write"}, 32'(ready_a), 32'd0);
        @(negedge clk);
        check({tag, ".count"}, 32'(count_a), 32'(exp_count));
        check({tag, ".we_drop"}, 32'(we_a), 32'd0);
    endtask

    task automatic write_b(input string tag, input int exp_addr, input int exp_count);
        @(negedge clk);
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        check({tag, ".we"}, 32'(we_b), 32'd1);
        check({tag, ".addr"}, 32'(addr_b), 32'(exp_addr));
        check({tag, ".wdata"}, wdata_b, 32'hE2801005);
        @(negedge clk);
        check({tag, ".count"}, 32'(count_b), 32'(exp_count));
    endtask

    initial begin
        reset = 1'b1;
        clear_a = 1'b0; valid_a = 1'b0;
        clear_b = 1'b0; valid_b = 1'b0;
        set_fields(4'hE, 2'b00, 4'b0100, 1'b0, 1'b1, 4'd0, 4'd1, 12'h005, 24'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst.ready", 32'(ready_a), 32'd1);
        check("rst.we", 32'(we_a), 32'd0);
        check("rst.addr", 32'(addr_a), 32'd0);
        check("rst.wdata", wdata_a, 32'h0);
        check("rst.count", 32'(count_a), 32'd0);
        check("rst.full", 32'(full_a), 32'd0);
        check("rst.err", 32'(err_a), 32'd0);

        // ADD r1, r0, #5
        set_fields(4'hE, 2'b00, 4'b0100, 1'b0, 1'b1, 4'd0, 4'd1, 12'h005, 24'h0);
        write_a("add", 0, 32'hE2801005, 1);
        // CMP forces S=1, Rd=0
        set_fields(4'hE, 2'b00, 4'b1010, 1'b0, 1'b0, 4'd2, 4'd7, 12'h003, 24'h0);
        write_a("cmp", 1, 32'hE1520003, 2);
        // LDR r3, [r0, #4]
        set_fields(4'hE, 2'b01, 4'b0001, 1'b0, 1'b1, 4'd0, 4'd3, 12'h004, 24'h0);
        write_a("ldr", 2, 32'hE5903004, 3);
        // EORS r2, r1, #0xFF
        set_fields(4'hE, 2'b00, 4'b0001, 1'b1, 1'b1, 4'd1, 4'd2, 12'h0FF, 24'h0);
        write_a("eor", 3, 32'hE23120FF, 4);
        // STR r5, [r4, r2] (register offset: I bit set in word)
        set_fields(4'hE, 2'b01, 4'b0000, 1'b0, 1'b0, 4'd4, 4'd5, 12'h002, 24'h0);
        write_a("str", 4, 32'hE7845002, 5);
`ifdef ENC_ABS_BRANCH_EN
        set_fields(4'hE, 2'b10, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'h000002);
`else
        set_fields(4'hE, 2'b10, 4'b0000, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'hFFFFFB);
`endif
        write_a("b", 5, 32'hEAFFFFFB, 6);

        // illegal op 11 is consumed without a write
        set_fields(4'hE, 2'b11, 4'b0100, 1'b0, 1'b1, 4'd0, 4'd1, 12'h005, 24'h0);
        @(negedge clk);
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check("ill.we", 32'(we_a), 32'd0);
        check("ill.err", 32'(err_a), 32'd1);
        check("ill.ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        check("ill.count", 32'(count_a), 32'd6);
        set_fields(4'hE, 2'b00, 4'b0100, 1'b0, 1'b1, 4'd0, 4'd1, 12'h005, 24'h0);
        write_a("add2", 6, 32'hE2801005, 7);
        check("add2.err_sticky", 32'(err_a), 32'd1);

        // small instance: illegal DP cmd sets err, then fill to DEPTH
        set_fields(4'hE, 2'b00, 4'b0011, 1'b0, 1'b1, 4'd0, 4'd1, 12'h005, 24'h0);
        @(negedge clk);
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        check("b.ill.we", 32'(we_b), 32'd0);
        check("b.ill.err", 32'(err_b), 32'd1);
        set_fields(4'hE, 2'b00, 4'b0100, 1'b0, 1'b1, 4'd0, 4'd1, 12'h005, 24'h0);
        write_b("b.w0", 0, 1);
        write_b("b.w1", 1, 2);
        write_b("b.w2", 2, 3);
        write_b("b.w3", 3, 4);
        check("b.full", 32'(full_b), 32'd1);
        check("b.ready_full", 32'(ready_b), 32'd0);
        @(negedge clk);
        valid_b = 1'b1;
        @(negedge clk);
        check("b.full_we", 32'(we_b), 32'd0);
        @(negedge clk);
        valid_b = 1'b0;
        check("b.full_count", 32'(count_b), 32'd4);
        clear_b = 1'b1;
        @(negedge clk);
        clear_b = 1'b0;
        check("b.clr.count", 32'(count_b), 32'd0);
        check("b.clr.full", 32'(full_b), 32'd0);
        check("b.clr.err", 32'(err_b), 32'd0);
        check("b.clr.ready", 32'(ready_b), 32'd1);
        write_b("b.w4", 0, 1);

        // reset during WRITE abandons the strobe
        @(negedge clk);
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        check("rstw.we", 32'(we_a), 32'd1);
        check("rstw.addr", 32'(addr_a), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstw.we_low", 32'(we_a), 32'd0);
        check("rstw.count", 32'(count_a), 32'd0);
        check("rstw.err", 32'(err_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
